// File: rtl/nwc_job_scheduler_if.sv
// Requester/accelerator signal bundle for nwc_job_scheduler.
// The scheduler takes the slave modport; the requester/accelerator side takes master.
interface nwc_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   bank_sel;
    logic [NUM_REQ-1:0] job_done;
    logic               job_err;
    logic               busy;
    logic               nwc_start;
    logic               nwc_done;

    modport slave (
        input  req,
        input  nwc_done,
        output grant,
        output bank_sel,
        output job_done,
        output job_err,
        output busy,
        output nwc_start
    );

    modport master (
        output req,
        output nwc_done,
        input  grant,
        input  bank_sel,
        input  job_done,
        input  job_err,
        input  busy,
        input  nwc_start
    );
endinterface

// File: rtl/nwc_job_scheduler.sv
// Round-robin scheduler sharing one nwc_top among NUM_REQ requesters, with a
// bank-select settle phase, edge-detected completion and a hung-job timeout.
module nwc_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input logic                clk,
    input logic                rst_n,
    nwc_job_scheduler_if.slave bus
);
    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned SET_W = 4;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StStart,
        StWait,
        StComplete
    } state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SET_W-1:0]   settle_q;
    logic               err_q;
    logic               done_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [SEL_W-1:0]   bank_sel_q;
    logic [NUM_REQ-1:0] job_done_q;
    logic               job_err_q;
    logic               busy_q;
    logic               nwc_start_q;

    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   idx;
    logic               found;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [SEL_W-1:0]   rr_next;
    logic               done_edge;

    // First pending requester at or after rr_q, wrapping.
    always_comb begin
        pick  = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = SEL_W'((32'(rr_q) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign sel_onehot = ONE << sel_q;
    assign rr_next    = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
    assign done_edge  = bus.nwc_done && !done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            settle_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b1;
            grant_q     <= '0;
            bank_sel_q  <= '0;
            job_done_q  <= '0;
            job_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            nwc_start_q <= 1'b0;
        end else begin
            done_q <= bus.nwc_done;

            // Outputs are registered images of the current state, one cycle behind it.
            busy_q      <= (state_q != StIdle);
            nwc_start_q <= (state_q == StStart);
            grant_q     <= (state_q != StIdle) ? sel_onehot : '0;
            bank_sel_q  <= sel_q;
            job_done_q  <= (state_q == StComplete) ? sel_onehot : '0;
            job_err_q   <= (state_q == StComplete) && err_q;

            case (state_q)
                StIdle: begin
                    if (|bus.req) begin
                        sel_q    <= pick;
                        settle_q <= '0;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= StStart;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // A done edge beats a timeout landing in the same cycle.
                    if (done_edge) begin
                        err_q   <= 1'b0;
                        state_q <= StComplete;
                    end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StComplete;
                    end
                end
                StComplete: begin
                    rr_q    <= rr_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bank_sel  = bank_sel_q;
    assign bus.job_done  = job_done_q;
    assign bus.job_err   = job_err_q;
    assign bus.busy      = busy_q;
    assign bus.nwc_start = nwc_start_q;
endmodule

// File: tb/tb_nwc_job_scheduler.sv
// Directed and randomized bench for nwc_job_scheduler against a round-robin
// job model with cycle-level expectations for grant, start and completion.
module tb_nwc_job_scheduler;
    localparam int unsigned NR = 4;
    localparam int          TO = 100;
    localparam int          ST = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nwc_job_scheduler_if #(.NUM_REQ(NR)) bus ();

    nwc_job_scheduler #(
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(TO),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int rr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (r[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    // One job: lo_d/hi_d are the cycle offsets after nwc_start at which the
    // accelerator lowers/raises done (negative = never).
    task automatic do_job(input logic [NR-1:0] r, input int lo_d, input int hi_d,
                          input bit scramble);
        int w, t, s_cnt, rise, got_t, exp_t;
        bit exp_err, stable, extra_start, bad_err;
        logic [NR-1:0] oh, g0;
        logic [1:0] b0;
        w = rr_pick(r, rr);
        oh = '0;
        oh[w] = 1'b1;
        bus.req = r;
        t = 0;
        while (t < 10) begin
            @(negedge clk);
            t++;
            if (t == 1) check("idle_before_grant",
                              {bus.busy, bus.nwc_start, bus.job_done, bus.grant}, 0);
            if (bus.grant != 0) break;
        end
        check("req_to_grant", t, 2);
        check("grant_onehot", bus.grant, oh);
        check("bank_sel", bus.bank_sel, w);
        g0 = bus.grant;
        b0 = bus.bank_sel;
        stable = 1'b1;
        if (scramble) bus.req = NR'($urandom);
        s_cnt = 0;
        while (!bus.nwc_start && s_cnt < 20) begin
            @(negedge clk);
            s_cnt++;
            if (bus.grant !== g0 || bus.bank_sel !== b0) stable = 1'b0;
        end
        check("grant_to_start", s_cnt, ST);
        rise = -1;
        got_t = -1;
        extra_start = 1'b0;
        bad_err = 1'b0;
        t = 0;
        while (got_t < 0 && t < TO + 20) begin
            @(negedge clk);
            t++;
            if (bus.grant !== g0 || bus.bank_sel !== b0) stable = 1'b0;
            if (bus.nwc_start) extra_start = 1'b1;
            if (bus.job_done != 0) got_t = t;
            else if (bus.job_err) bad_err = 1'b1;
            if (t == lo_d) bus.nwc_done = 1'b0;
            if (t == hi_d) begin
                if (!bus.nwc_done && rise < 0) rise = t;
                bus.nwc_done = 1'b1;
            end
        end
        // Completion two cycles after a timely done rise, else TO+1 after start.
        if (rise >= 0 && rise <= TO - 1) begin
            exp_t = rise + 2;
            exp_err = 1'b0;
        end else begin
            exp_t = TO + 1;
            exp_err = 1'b1;
        end
        check("done_latency", got_t, exp_t);
        check("job_done_vec", bus.job_done, oh);
        check("job_err", bus.job_err, exp_err);
        check("grant_at_done", bus.grant, oh);
        check("single_start", extra_start, 0);
        check("bank_sel_stable", stable, 1);
        check("err_qualified", bad_err, 0);
        rr = (w + 1) % NR;
    endtask

    initial begin
        int s;
        bit seen;
        logic [NR-1:0] r;
        int lo, hi;

        bus.req = '0;
        bus.nwc_done = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.busy, bus.nwc_start, bus.job_done, bus.job_err,
                              bus.grant, bus.bank_sel}, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.job_done != 0 || bus.nwc_start) seen = 1'b1;
        end
        check("idle_no_req", seen, 0);

        do_job(4'b0001, 10, 60, 1'b0);
        do_job(4'b0010, -1, -1, 1'b0);   // done still high from last job: no edge
        do_job(4'b0011, 5, 30, 1'b0);    // rr at 2 wraps to 0
        do_job(4'b0011, 5, 30, 1'b0);
        for (int i = 0; i < 5; i++) do_job(4'b1111, 3, 8 + i * 7, 1'b0);
        do_job(4'b0100, 3, -1, 1'b0);    // held low: timeout
        do_job(4'b0100, 3, 40, 1'b0);
        do_job(4'b1000, 3, TO - 1, 1'b0); // edge and timeout coincide
        do_job(4'b1000, 3, TO, 1'b0);     // edge one cycle too late
        do_job(4'b0001, 2, 12, 1'b1);

        // Reset while waiting on the accelerator.
        bus.req = 4'b1111;
        s = 0;
        while (!bus.nwc_start && s < 20) begin
            @(negedge clk);
            s++;
        end
        check("abort_start_seen", bus.nwc_start, 1);
        bus.req = '0;
        bus.nwc_done = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_abort", {bus.busy, bus.nwc_start, bus.grant, bus.job_done}, 0);
        rst_n = 1'b1;
        bus.nwc_done = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.job_done != 0 || bus.nwc_start || bus.busy) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 0);
        rr = 0;
        do_job(4'b1111, 3, 20, 1'b0);

        for (int i = 0; i < 25; i++) begin
            r = NR'($urandom_range(1, 15));
            lo = int'($urandom_range(1, 5));
            if ($urandom_range(0, 7) == 0) hi = -1;
            else hi = lo + int'($urandom_range(1, TO + 10));
            do_job(r, lo, hi, 1'($urandom_range(0, 1)));
        end

        bus.req = '0;
        @(negedge clk);
        check("final_idle", {bus.busy, bus.nwc_start, bus.grant, bus.job_done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
